// File: rtl/ddr3_read_checker.sv
// ----------------------------------------------------------------------------
// ddr3_read_checker
//
// Checks the DDR3 controller's read-return stream against a seeded 32-bit LFSR
// pattern. The write side produces the same pattern from the same seed. Each
// expected beat is {l, ~l}. The checker reports pass/fail, timeout, the error
// count, and the index and data of the first mismatching beat.
//
// Ports
//   clk              DDR3 user clock (ddr3_sclk)
//   rst              asynchronous, active-high reset
//   start            one-cycle pulse that arms a run (ignored while busy)
//   seed             LFSR seed, sampled on an accepted start (0 maps to 1)
//   num_beats        expected beat count, sampled on an accepted start
//   read_data        read beat from the controller
//   read_data_valid  qualifies read_data
//   busy             high while a run is in progress
//   done             high once the run has ended, until the next accepted start
//   pass             done with no mismatches and no timeout
//   timeout          run aborted because beats stopped arriving
//   err_count        number of mismatched beats (saturating)
//   first_err_idx    0-based index of the first mismatching beat
//   first_err_data   received data of the first mismatching beat
//   stray            sticky: valid beat seen while no run was active
// ----------------------------------------------------------------------------
module ddr3_read_checker #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] num_beats,
    input  logic [63:0]      read_data,
    input  logic             read_data_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [63:0]      first_err_data,
    output logic             stray
);

    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW:0] TMO_LAST = (TW + 1)'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic [31:0]      lfsr_r;
    logic [CNT_W-1:0] num_beats_r;
    logic [CNT_W-1:0] beat_cnt_r;
    logic [TW-1:0]    tcnt_r;
    logic [CNT_W-1:0] err_count_r;
    logic [CNT_W-1:0] first_err_idx_r;
    logic [63:0]      first_err_data_r;
    logic             timeout_r;
    logic             stray_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;

    logic             busy_s;
    logic             done_s;
    logic             pass_s;
    logic             start_acc_s;
    logic             beat_s;
    logic             mismatch_s;
    logic             last_beat_s;
    logic             tmo_hit_s;
    logic [63:0]      exp_beat_s;

    // Galois-free Fibonacci LFSR step, taps 31/21/1/0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Seed 0 would lock the LFSR, so it is mapped to 1.
    function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
        return (s == 32'h0000_0000) ? 32'h0000_0001 : s;
    endfunction

    assign exp_beat_s  = {lfsr_r, ~lfsr_r};
    assign start_acc_s = start && (state_r != CHECK);
    assign beat_s      = read_data_valid && (state_r == CHECK);
    assign mismatch_s  = beat_s && (read_data != exp_beat_s);
    assign last_beat_s = beat_s &&
                         (({1'b0, beat_cnt_r} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, num_beats_r});
    // Abort on the idle cycle that brings the idle counter to TIMEOUT-1.
    assign tmo_hit_s   = (state_r == CHECK) && !read_data_valid &&
                         (({1'b0, tcnt_r} + {{TW{1'b0}}, 1'b1}) == TMO_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = (num_beats == {CNT_W{1'b0}}) ? DONE : CHECK;
                end else begin
                    state_next_s = state_r;
                end
            end
            CHECK: begin
                if (last_beat_s || tmo_hit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CHECK;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output decode; pass is resolved on the transition into DONE and then held.
    always_comb begin
        busy_s = (state_next_s == CHECK);
        done_s = (state_next_s == DONE);
        pass_s = pass_r;
        if (start_acc_s) begin
            pass_s = (num_beats == {CNT_W{1'b0}});
        end else if (last_beat_s) begin
            pass_s = !timeout_r && (err_count_r == {CNT_W{1'b0}}) && !mismatch_s;
        end else if (tmo_hit_s) begin
            pass_s = 1'b0;
        end else begin
            pass_s = pass_r;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
            pass_r <= pass_s;
        end
    end

    // Pattern generator, counters, first-error capture and stray flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r           <= 32'h0000_0001;
            num_beats_r      <= {CNT_W{1'b0}};
            beat_cnt_r       <= {CNT_W{1'b0}};
            tcnt_r           <= {TW{1'b0}};
            err_count_r      <= {CNT_W{1'b0}};
            first_err_idx_r  <= {CNT_W{1'b0}};
            first_err_data_r <= 64'h0;
            timeout_r        <= 1'b0;
            stray_r          <= 1'b0;
        end else if (start_acc_s) begin
            // A beat coincident with an accepted start is neither checked nor stray.
            lfsr_r           <= lfsr_seed(seed);
            num_beats_r      <= num_beats;
            beat_cnt_r       <= {CNT_W{1'b0}};
            tcnt_r           <= {TW{1'b0}};
            err_count_r      <= {CNT_W{1'b0}};
            first_err_idx_r  <= {CNT_W{1'b0}};
            first_err_data_r <= 64'h0;
            timeout_r        <= 1'b0;
            stray_r          <= 1'b0;
        end else if (beat_s) begin
            lfsr_r     <= lfsr_step(lfsr_r);
            beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            tcnt_r     <= {TW{1'b0}};
            if (mismatch_s) begin
                if (err_count_r != {CNT_W{1'b1}}) begin
                    err_count_r <= err_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    err_count_r <= err_count_r;
                end
                // A zero count means no mismatch has been captured yet this run.
                if (err_count_r == {CNT_W{1'b0}}) begin
                    first_err_idx_r  <= beat_cnt_r;
                    first_err_data_r <= read_data;
                end else begin
                    first_err_idx_r  <= first_err_idx_r;
                    first_err_data_r <= first_err_data_r;
                end
            end else begin
                err_count_r <= err_count_r;
            end
        end else if (state_r == CHECK) begin
            tcnt_r <= tcnt_r + {{(TW-1){1'b0}}, 1'b1};
            if (tmo_hit_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end else if (read_data_valid) begin
            stray_r <= 1'b1;
        end else begin
            stray_r <= stray_r;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign timeout        = timeout_r;
    assign err_count      = err_count_r;
    assign first_err_idx  = first_err_idx_r;
    assign first_err_data = first_err_data_r;
    assign stray          = stray_r;

endmodule

// File: tb/tb_ddr3_read_checker.sv
// ----------------------------------------------------------------------------
// tb_ddr3_read_checker
//
// Scoreboard bench for ddr3_read_checker. Each run's expected result is
// computed up front from the pattern rules and queued; a monitor pops and
// compares whenever the DUT presents a new result on done.
// ----------------------------------------------------------------------------
module tb_ddr3_read_checker;

    localparam int TMO = 16;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   seed = 32'h0;
    logic [CW-1:0] num_beats = '0;
    logic [63:0]   read_data = 64'h0;
    logic          read_data_valid = 1'b0;
    logic          busy, done, pass, timeout, stray;
    logic [CW-1:0] err_count, first_err_idx;
    logic [63:0]   first_err_data;

    ddr3_read_checker #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .num_beats(num_beats),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_data(first_err_data), .stray(stray)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pass;
        logic          tmo;
        logic [CW-1:0] err;
        logic [CW-1:0] idx;
        logic [63:0]   data;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   armed_cnt  = 0;
    int   served_cnt = 0;

    logic [63:0] xmask [64];
    int          max_gap   = 0;
    int          start_mid = -1;
    bit          vld_with_start = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Monitor: a new result is due once a start has been accepted and done is high.
    exp_t mon_e;
    logic done_d = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1 && armed_cnt != served_cnt) begin
            served_cnt <= served_cnt + 1;
            if (exp_q.size() == 0) begin
                chk("result_without_expectation", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pass",           pass,           mon_e.pass);
                chk("timeout",        timeout,        mon_e.tmo);
                chk("err_count",      err_count,      mon_e.err);
                chk("first_err_idx",  first_err_idx,  mon_e.idx);
                chk("first_err_data", first_err_data, mon_e.data);
                chk("busy_in_done",   busy,           1'b0);
            end
        end else if (done === 1'b1 && done_d === 1'b0) begin
            chk("unarmed_done", 64'd1, 64'd0);
        end
        done_d <= done;
    end

    task automatic pulse_start(input logic [31:0] sd, input int n, input bit vws);
        @(posedge clk); #1;
        start = 1'b1; seed = sd; num_beats = CW'(n);
        read_data_valid = vws; read_data = {$urandom, $urandom};
        @(posedge clk); #1;
        start = 1'b0; read_data_valid = 1'b0;
        armed_cnt = armed_cnt + 1;
        chk("busy_after_start", busy, (n != 0));
        chk("stray_after_start", stray, 1'b0);
    endtask

    task automatic send_beat(input logic [63:0] d, input bit st);
        repeat ($urandom_range(max_gap, 0)) begin
            @(posedge clk); #1;
        end
        read_data = d; read_data_valid = 1'b1; start = st; seed = $urandom;
        num_beats = CW'($urandom_range(5, 1));
        @(posedge clk); #1;
        read_data_valid = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done(input int exp_k);
        int k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_latency", k, exp_k);
    endtask

    // One run: build expected result from the pattern rules, then drive it.
    task automatic do_run(input logic [31:0] sd, input int n, input int sent);
        logic [31:0] l;
        logic [63:0] beats [64];
        exp_t        e;
        l = (sd == 32'h0) ? 32'h1 : sd;
        e.err = '0; e.idx = '0; e.data = 64'h0;
        for (int i = 0; i < sent; i++) begin
            beats[i] = {l, ~l} ^ xmask[i];
            if (xmask[i] != 64'h0) begin
                if (e.err == '0) begin
                    e.idx  = CW'(i);
                    e.data = beats[i];
                end
                e.err = e.err + 1'b1;
            end
            l = ref_next(l);
        end
        e.tmo  = (sent < n);
        e.pass = !e.tmo && (e.err == '0);
        exp_q.push_back(e);
        pulse_start(sd, n, vld_with_start);
        for (int i = 0; i < sent; i++) begin
            send_beat(beats[i], (i == start_mid));
            if (i == start_mid) chk("busy_after_ignored_start", busy, (i < n - 1));
        end
        wait_done(e.tmo ? TMO - 1 : 0);
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 64; i++) xmask[i] = 64'h0;
        max_gap = 0; start_mid = -1; vld_with_start = 1'b0;
    endtask

    initial begin
        clear_cfg();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_stray", stray, 1'b0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err_idx", first_err_idx, 0);
        chk("rst_first_err_data", first_err_data, 64'h0);

        // Stray beat while idle.
        @(posedge clk); #1 read_data_valid = 1'b1; read_data = 64'h1234;
        @(posedge clk); #1 read_data_valid = 1'b0;
        chk("stray_idle", stray, 1'b1);
        chk("busy_idle", busy, 1'b0);

        // Clean back-to-back run, then the same with beats 3 and 5 corrupted.
        do_run(32'h1, 8, 8);
        xmask[3] = 64'h1; xmask[5] = 64'hDEAD_0000_0000_BEEF;
        do_run(32'h1, 8, 8);
        clear_cfg();

        // Seed 0 loads 1: first beat must be the literal pattern below.
        begin
            exp_t e;
            e.pass = 1'b1; e.tmo = 1'b0; e.err = '0; e.idx = '0; e.data = 64'h0;
            exp_q.push_back(e);
            pulse_start(32'h0, 1, 1'b0);
            send_beat(64'h0000_0001_FFFF_FFFE, 1'b0);
            wait_done(0);
        end

        // Zero-length run, timeouts, ignored starts, start+valid from DONE.
        do_run(32'hA5A5_0F0F, 0, 0);
        do_run(32'h0BAD_F00D, 4, 2);
        do_run(32'h7, 3, 0);
        start_mid = 2; max_gap = 2;
        do_run(32'hCAFE_0001, 6, 6);
        start_mid = 5;
        do_run(32'hCAFE_0002, 6, 6);
        chk("busy_after_final_with_start", busy, 1'b0);
        clear_cfg();
        vld_with_start = 1'b1;
        do_run(32'h1357_9BDF, 5, 5);
        clear_cfg();

        // Reset in the middle of a run with a mismatch already recorded.
        @(posedge clk); #1 read_data_valid = 1'b1;
        @(posedge clk); #1 read_data_valid = 1'b0;
        @(posedge clk); #1 start = 1'b1; seed = 32'h1; num_beats = CW'(8);
        @(posedge clk); #1 start = 1'b0;
        read_data = 64'h0; read_data_valid = 1'b1;
        @(posedge clk); #1 read_data_valid = 1'b0;
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_err", err_count, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrun_rst_outputs",
            {busy, done, pass, timeout, stray, err_count, first_err_idx},
            64'h0);
        chk("midrun_rst_first_err_data", first_err_data, 64'h0);
        @(posedge clk); #1 rst = 1'b0;
        do_run(32'h2468_ACE0, 10, 10);

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            int n, sent;
            clear_cfg();
            max_gap = 3;
            n = $urandom_range(40, 1);
            sent = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : n;
            for (int i = 0; i < sent; i++) begin
                if ($urandom_range(4, 0) == 0) xmask[i] = 64'h1 << $urandom_range(63, 0);
            end
            if (sent == n && $urandom_range(1, 0) == 1) start_mid = $urandom_range(n - 1, 0);
            vld_with_start = $urandom_range(1, 0);
            do_run($urandom, n, sent);
        end

        @(posedge clk); @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ddr3_read_checker.md
# ddr3_read_checker

Compares the DDR3 controller's read-return stream against a seeded LFSR pattern and reports pass/fail, error count and first-failure details. Sits directly downstream of the DDR3 local user interface, on the read side: `read_data` and `read_data_valid` feed in, in the `ddr3_sclk` domain. The matching write stage produces the same pattern from the same seed. Its results drive status GPIO and debug logic.

## Interface
Parameters:
- `TIMEOUT`, 4096: sclk cycles allowed between consecutive valid beats (or between start and first beat) before abort.
- `CNT_W`, 16: width of beat and error counters.

Ports:
- `clk`  in  1  DDR3 user clock (`ddr3_sclk`).
- `rst`  in  1  Reset; asynchronous, active-high.
- `start`  in  1  One-cycle pulse; arms a check run.
- `seed`  in  32  LFSR seed, sampled on accepted `start`.
- `num_beats`  in  CNT_W  Expected beat count, sampled on accepted `start`.
- `read_data`  in  64  Read beat from controller.
- `read_data_valid`  in  1  Qualifies `read_data`.
- `busy`  out  1  High in CHECK.
- `done`  out  1  High in DONE; holds until next accepted `start`.
- `pass`  out  1  Valid while `done`=1: no mismatches and no timeout.
- `timeout`  out  1  Run aborted on timeout; valid while `done`=1.
- `err_count`  out  CNT_W  Mismatched beats; saturates at all-ones.
- `first_err_idx`  out  CNT_W  Beat index (0-based) of first mismatch.
- `first_err_data`  out  64  Received data of first mismatch.
- `stray`  out  1  Sticky: valid beat seen outside CHECK; cleared by accepted `start`.

## Operation
- Pattern: 32-bit LFSR `l`. Expected beat = `{l, ~l}`. Next `l` = `{l[30:0], l[31]^l[21]^l[1]^l[0]}`. A `seed` of 0 loads 32'h0000_0001.
- States: IDLE, CHECK, DONE. Reset enters IDLE.
- IDLE or DONE, `start`=1:
  - Load `l`, beat counter = 0, timeout counter = 0.
  - Clear `err_count`, `first_err_idx`, `first_err_data`, `timeout`, `stray`.
  - Go to CHECK. If `num_beats`=0, go straight to DONE with `pass`=1.
- CHECK, `read_data_valid`=1:
  - Compare `read_data` to the expected beat, then advance `l` and the beat counter.
  - On mismatch, increment `err_count` (saturating).
  - On the first mismatch, capture the index and the data.
  - Reset the timeout counter.
  - When beat counter + 1 == `num_beats`, go to DONE.
- CHECK, no valid: increment the timeout counter. When it reaches `TIMEOUT`-1, go to DONE with `timeout`=1.
- `start` during CHECK is ignored. There is no restart mid-run.
- `read_data_valid` in IDLE or DONE sets `stray` and is otherwise ignored.
- `pass` = `done` & ~`timeout` & (`err_count`==0).
- Reset mid-run: all state and outputs return to reset values immediately; the run is lost.

## Timing
- Reset values:
  - `busy` = `done` = `pass` = `timeout` = `stray` = 0.
  - Counters and capture registers = 0.
  - `l` = 1.
- `busy` rises the cycle after an accepted `start`.
- `err_count` and the first-error capture update the cycle after the offending beat.
- `done` and `pass` rise the cycle after the final valid beat is sampled. Result latency is 1 clk.
- Back-to-back valid beats are accepted every cycle. There is no backpressure.
- `start` coincident with the final beat: the beat completes the current run and `start` is ignored.
- `start` and valid in the same cycle from IDLE/DONE: `start` is accepted and the beat is not checked. `stray` still ends 0.
- Saturation: `err_count` holds at 2^CNT_W−1.

## Test plan
- Seed 32'h1, `num_beats`=8, 8 correct beats back-to-back -> `done`=1 one clk after beat 7, `pass`=1, `err_count`=0.
- Same run with beat 3 bit 0 flipped and beat 5 corrupted -> `err_count`=2, `first_err_idx`=3, `first_err_data`= the flipped beat 3, `pass`=0.
- `seed`=0 -> first expected beat 64'h00000001_FFFFFFFE. `num_beats`=0 -> `done`=1 and `pass`=1 one clk after `start`.
- `TIMEOUT`=16, 2 of 4 beats sent, then idle -> `done`=1 and `timeout`=1 after 15 idle cycles, `pass`=0.
- Valid pulse in IDLE -> `stray`=1. Then `start`, then assert `rst` mid-CHECK -> all outputs 0 the same cycle. A new run after reset passes.
- `start` pulsed during CHECK -> ignored: `busy` stays high and the run's results are unchanged.
